div_ctrl: RTL and testbench

- EX-stage initiator for the iterative divider: accepts a DIV/DIVU/REM/REMU request from EX and stalls the pipeline until the result is ready.
- Resolves divide-by-zero and signed overflow locally, reuses the previous 64-bit divider result for a matching operand pair (DIV+REM fusion), and otherwise drives the divider's start/annul/ready handshake.
- Returns the selected 32-bit quotient or remainder to EX.

---
 rtl/div_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_div_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// ============================================================================
// Module      : div_ctrl
// Description : EX-stage front end for the iterative divider. Handles divide
//               by zero and signed overflow locally, reuses the last result
//               for the same operand pair, and otherwise runs the divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_ctrl #(
    parameter bit CACHE_EN     = 1'b1,
    parameter bit FAST_PATH_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        req_valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        result_valid_o,
    output logic [31:0] result_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divisor_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_start;
    logic        w_start_nxt;
    logic        r_annul;
    logic        w_annul_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        r_sel_rem;
    logic        r_signed;
    logic [31:0] r_dividend;
    logic [31:0] r_divisor;
    logic [63:0] r_res;
    logic [31:0] r_result;

    logic        r_c_valid;
    logic        r_c_signed;
    logic [31:0] r_c_rs1;
    logic [31:0] r_c_rs2;
    logic [63:0] r_c_res;

    logic        w_req_signed;
    logic        w_div0;
    logic        w_ovf;
    logic        w_hit;
    logic        w_accept;
    logic        w_capture;

    assign w_req_signed = ~op_i[0];
    assign w_div0       = FAST_PATH_EN && (rs2_i == 32'h0000_0000);
    assign w_ovf        = FAST_PATH_EN && w_req_signed &&
                          (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
    assign w_hit        = CACHE_EN && r_c_valid &&
                          ({r_c_signed, r_c_rs1, r_c_rs2} == {w_req_signed, rs1_i, rs2_i});
    // The result-valid cycle still sees the old request, so it must not re-accept.
    assign w_accept     = (r_state == IDLE) && req_valid_i && !flush_i && !r_valid;
    assign w_capture    = (r_state == RUN) && div_ready_i && !flush_i;

    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = r_start;
        w_annul_nxt = 1'b0;
        w_valid_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_div0 || w_ovf || w_hit) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                        w_start_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (flush_i) begin
                    w_state_nxt = ABORT;
                    w_start_nxt = 1'b0;
                    w_annul_nxt = 1'b1;
                end else if (div_ready_i) begin
                    w_state_nxt = DONE;
                    w_start_nxt = 1'b0;
                end
            end
            DONE: begin
                w_valid_nxt = 1'b1;
                w_state_nxt = IDLE;
            end
            ABORT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_start_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (n_rst_i) begin
            r_state    <= IDLE;
            r_start    <= 1'b0;
            r_annul    <= 1'b0;
            r_valid    <= 1'b0;
            r_sel_rem  <= 1'b0;
            r_signed   <= 1'b0;
            r_dividend <= 32'h0;
            r_divisor  <= 32'h0;
            r_res      <= 64'h0;
            r_result   <= 32'h0;
            r_c_valid  <= 1'b0;
            r_c_signed <= 1'b0;
            r_c_rs1    <= 32'h0;
            r_c_rs2    <= 32'h0;
            r_c_res    <= 64'h0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_annul <= w_annul_nxt;
            r_valid <= w_valid_nxt;
            if (w_accept) begin
                r_sel_rem  <= op_i[1];
                r_signed   <= w_req_signed;
                r_dividend <= rs1_i;
                r_divisor  <= rs2_i;
                if (w_div0) begin
                    r_res <= {rs1_i, 32'hFFFF_FFFF};
                end else if (w_ovf) begin
                    r_res <= {32'h0000_0000, 32'h8000_0000};
                end else if (w_hit) begin
                    r_res <= r_c_res;
                end
            end
            if (w_capture) begin
                r_res      <= div_result_i;
                r_c_valid  <= 1'b1;
                r_c_signed <= r_signed;
                r_c_rs1    <= r_dividend;
                r_c_rs2    <= r_divisor;
                r_c_res    <= div_result_i;
            end
            if (r_state == DONE) begin
                r_result <= r_sel_rem ? r_res[63:32] : r_res[31:0];
            end
        end
    end

    // Once the divider is running, EX must hold the request until flushed.
    a_req_held: assert property (@(posedge clk_i) disable iff (n_rst_i)
        (r_state == RUN) |-> (req_valid_i || flush_i));

    assign stall_o        = req_valid_i & ~r_valid;
    assign result_valid_o = r_valid;
    assign result_o       = r_result;
    assign div_start_o    = r_start;
    assign div_annul_o    = r_annul;
    assign div_signed_o   = r_signed;
    assign div_dividend_o = r_dividend;
    assign div_divisor_o  = r_divisor;

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// ============================================================================
// Module      : tb_div_ctrl
// Description : Directed self-checking bench for div_ctrl with a simple
//               fixed-latency divider responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_ctrl;

    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic        req_valid_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        stall_o;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divisor_o;
    logic        div_ready_i;
    logic [63:0] div_result_i;

    int vectors    = 0;
    int miscompares = 0;
    int div_lat    = 4;
    int div_cnt    = 0;

    div_ctrl #(.CACHE_EN(1'b1), .FAST_PATH_EN(1'b1)) dut (
        .clk_i          (clk_i),
        .n_rst_i        (n_rst_i),
        .req_valid_i    (req_valid_i),
        .op_i           (op_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .div_start_o    (div_start_o),
        .div_annul_o    (div_annul_o),
        .div_signed_o   (div_signed_o),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_ready_i    (div_ready_i),
        .div_result_i   (div_result_i)
    );

    always #5 clk_i = ~clk_i;

    // Divider responder: ready pulses div_lat cycles after start rises.
    always @(negedge clk_i) begin
        div_ready_i = 1'b0;
        if (n_rst_i || !div_start_o) begin
            div_cnt = 0;
        end else begin
            div_cnt = div_cnt + 1;
            if (div_cnt == div_lat) begin
                div_ready_i = 1'b1;
                if (div_divisor_o == 32'h0) begin
                    div_result_i = {div_dividend_o, 32'hFFFF_FFFF};
                end else if (div_signed_o) begin
                    div_result_i = {32'($signed(div_dividend_o) % $signed(div_divisor_o)),
                                    32'($signed(div_dividend_o) / $signed(div_divisor_o))};
                end else begin
                    div_result_i = {div_dividend_o % div_divisor_o,
                                    div_dividend_o / div_divisor_o};
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input logic exp_start);
        int   n;
        logic seen_start;
        logic got;
        logic stall_bad;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        op_i        = op;
        rs1_i       = a;
        rs2_i       = b;
        n          = 0;
        seen_start = 1'b0;
        got        = 1'b0;
        stall_bad  = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
            if (div_start_o) seen_start = 1'b1;
            if (result_valid_o) got = 1'b1;
            else if (stall_o !== 1'b1) stall_bad = 1'b1;
        end
        check({tag, " valid"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, " result"}, result_o, exp);
            check({tag, " stall_on_valid"}, 32'(stall_o), 32'd0);
            check({tag, " latency"}, n, exp_lat);
        end
        check({tag, " stall_before"}, 32'(stall_bad), 32'd0);
        check({tag, " start_seen"}, 32'(seen_start), 32'(exp_start));
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    initial begin
        logic seen_valid;
        n_rst_i      = 1'b1;
        req_valid_i  = 1'b0;
        op_i         = 2'b00;
        rs1_i        = 32'h0;
        rs2_i        = 32'h0;
        flush_i      = 1'b0;
        div_ready_i  = 1'b0;
        div_result_i = 64'h0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst start", 32'(div_start_o), 32'd0);
        check("rst annul", 32'(div_annul_o), 32'd0);
        check("rst valid", 32'(result_valid_o), 32'd0);
        check("rst result", result_o, 32'h0);
        check("rst dividend", div_dividend_o, 32'h0);
        @(negedge clk_i);
        n_rst_i = 1'b0;

        // Divider path: 1 accept + 4 run + 1 done cycles.
        do_op("DIV 100/7", 2'b00, 32'd100, 32'd7, 32'h0000_000E, 6, 1'b1);
        check("opnd dividend", div_dividend_o, 32'd100);
        check("opnd divisor", div_divisor_o, 32'd7);
        check("opnd signed", 32'(div_signed_o), 32'd1);

        do_op("DIV -100/7", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 6, 1'b1);
        do_op("REM -100/7 hit", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 2, 1'b0);

        do_op("DIVU 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
        do_op("REMU 5/0", 2'b11, 32'd5, 32'd0, 32'h0000_0005, 2, 1'b0);
        do_op("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
        do_op("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1'b0);

        do_op("DIVU ffffffff/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 6, 1'b1);
        check("opnd unsigned", 32'(div_signed_o), 32'd0);
        do_op("DIV ffffffff/1", 2'b00, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 6, 1'b1);

        // Flush 10 cycles into a long divider run.
        div_lat = 30;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        op_i        = 2'b00;
        rs1_i       = 32'd9;
        rs2_i       = 32'd3;
        repeat (11) @(posedge clk_i);
        #1;
        check("flush pre start", 32'(div_start_o), 32'd1);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("flush annul", 32'(div_annul_o), 32'd1);
        check("flush start", 32'(div_start_o), 32'd0);
        @(negedge clk_i);
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("flush annul one", 32'(div_annul_o), 32'd0);
        seen_valid = 1'b0;
        repeat (5) begin
            @(posedge clk_i);
            #1;
            if (result_valid_o) seen_valid = 1'b1;
        end
        check("flush no valid", 32'(seen_valid), 32'd0);
        div_lat = 4;
        do_op("DIV 9/3 post flush", 2'b00, 32'd9, 32'd3, 32'd3, 6, 1'b1);

        // Reset in the middle of a divider run invalidates the cache.
        do_op("DIV 17/5", 2'b00, 32'd17, 32'd5, 32'd3, 6, 1'b1);
        div_lat = 30;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        op_i        = 2'b00;
        rs1_i       = 32'd20;
        rs2_i       = 32'd3;
        repeat (6) @(posedge clk_i);
        @(negedge clk_i);
        n_rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("midrst start", 32'(div_start_o), 32'd0);
        check("midrst annul", 32'(div_annul_o), 32'd0);
        check("midrst valid", 32'(result_valid_o), 32'd0);
        check("midrst result", result_o, 32'h0);
        check("midrst dividend", div_dividend_o, 32'h0);
        check("midrst divisor", div_divisor_o, 32'h0);
        check("midrst signed", 32'(div_signed_o), 32'd0);
        @(negedge clk_i);
        n_rst_i     = 1'b0;
        req_valid_i = 1'b0;
        div_lat     = 4;
        do_op("REM 17/5 post rst", 2'b10, 32'd17, 32'd5, 32'd2, 6, 1'b1);

        repeat (2) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
